// File: rtl/dmem_rd_arbiter.sv
// Round-robin two-port read arbiter with a registered response bus in front of the data-memory ROM.
// Optional range checking of requests is enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_rd_arbiter #(
  parameter int S    = 32,
  parameter int V    = 192,
  parameter int SIZE = 30000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [S-1:0] addr0,
  input  logic [S-1:0] addr1,
  input  logic         vec0,
  input  logic         vec1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [V-1:0] rdata,
  output logic         rerr,
  output logic         rom_isVector,
  output logic [S-1:0] rom_address,
  input  logic [V-1:0] rom_rd
);

  localparam int NW = V / S;

  logic         last_p1;
  logic         vld0_p1;
  logic         vld1_p1;
  logic         err_p1;
  logic [V-1:0] data_p1;

  logic         any_gnt;
  logic [S-1:0] sel_addr;
  logic         sel_vec;
  logic         oor;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  // Last word address is formed one bit wider so an address carry-out counts as out of range.
  function automatic logic out_of_range(input logic [S-1:0] a, input logic v);
    logic [S:0] last_word;
    last_word = {1'b0, a} + (v ? (S+1)'(NW - 1) : (S+1)'(0));
    return last_word > (S+1)'(SIZE - 1);
  endfunction
`endif

  // Stage p0: combinational arbitration and ROM drive
  always_comb begin
    gnt0     = !rst && req0 && (!req1 || last_p1);
    gnt1     = !rst && req1 && (!req0 || !last_p1);
    any_gnt  = gnt0 || gnt1;
    sel_addr = gnt1 ? addr1 : addr0;
    sel_vec  = gnt1 ? vec1  : vec0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    oor      = any_gnt && out_of_range(sel_addr, sel_vec);
`else
    oor      = 1'b0;
`endif
    rom_address  = (any_gnt && !oor) ? sel_addr : '0;
    rom_isVector = any_gnt && !oor && sel_vec;
  end

  // Stage p1: registered response and priority pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_p1 <= 1'b1;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      err_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld0_p1 <= gnt0;
      vld1_p1 <= gnt1;
      err_p1  <= oor;
      if (gnt0)
        last_p1 <= 1'b0;
      else if (gnt1)
        last_p1 <= 1'b1;
      if (any_gnt)
        data_p1 <= oor ? '0 : rom_rd;
    end
  end

  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;
  assign rerr    = err_p1;
  assign rdata   = data_p1;

endmodule

// File: tb/tb_dmem_rd_arbiter.sv
// Directed bench for dmem_rd_arbiter with a behavioral ROM; bounds tests follow DMEM_ARB_BOUNDS_CHECK_EN.
module tb_dmem_rd_arbiter;

  localparam int S    = 32;
  localparam int V    = 192;
  localparam int SIZE = 30000;
  localparam int NW   = V / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [S-1:0] addr0, addr1;
  logic         vec0, vec1;
  logic         gnt0, gnt1;
  logic         rvalid0, rvalid1;
  logic [V-1:0] rdata;
  logic         rerr;
  logic         rom_isVector;
  logic [S-1:0] rom_address;
  logic [V-1:0] rom_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_rd_arbiter #(.S(S), .V(V), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .vec0(vec0), .vec1(vec1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rerr(rerr),
    .rom_isVector(rom_isVector), .rom_address(rom_address),
    .rom_rd(rom_rd)
  );

  // ROM contents: word a = {~a[15:0], a[15:0]}; addresses past the end read as 0
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a < SIZE) ? {~a[15:0], a[15:0]} : 32'h0;
  endfunction

  function automatic logic [V-1:0] words(input logic [31:0] a, input int n);
    logic [V-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*32 +: 32] = word(a + 32'(k));
    return r;
  endfunction

  always_comb rom_rd = words(rom_address, rom_isVector ? NW : 1);

  task automatic idle_inputs();
    req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; vec0 = 0; vec1 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    step(); step();
    n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid0: got %b expected 0", rvalid0); end
    n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid1: got %b expected 0", rvalid1); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL reset_rerr: got %b expected 0", rerr); end
    n_checks++; if (rom_address !== '0 || rom_isVector !== 1'b0) begin n_fail++; $display("FAIL reset_rom: got addr %h vec %b expected 0 0", rom_address, rom_isVector); end
    req0 = 1; req1 = 1; addr0 = 32'd5; addr1 = 32'd7;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_forced: got %b%b expected 00", gnt0, gnt1); end
    rst = 0;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL first_tie: got %b%b expected 10", gnt0, gnt1); end
    n_checks++; if (rom_address !== 32'd5) begin n_fail++; $display("FAIL first_tie_addr: got %0d expected 5", rom_address); end
    step();
    idle_inputs();
    n_checks++; if ({rvalid0, rvalid1} !== 2'b10 || rdata !== words(32'd5, 1)) begin n_fail++; $display("FAIL first_tie_resp: got v%b%b %h expected v10 %h", rvalid0, rvalid1, rdata, words(32'd5, 1)); end
    step();
  endtask

  task automatic test_scalar();
    req0 = 1; addr0 = 32'd10; vec0 = 0;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL scalar_gnt: got %b%b expected 10", gnt0, gnt1); end
    step();
    idle_inputs();
    n_checks++; if ({rvalid0, rvalid1} !== 2'b10) begin n_fail++; $display("FAIL scalar_rvalid: got %b%b expected 10", rvalid0, rvalid1); end
    n_checks++; if (rdata !== {160'h0, 32'hFFF5_000A}) begin n_fail++; $display("FAIL scalar_rdata: got %h expected %h", rdata, {160'h0, 32'hFFF5_000A}); end
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL scalar_rerr: got %b expected 0", rerr); end
    step();
    n_checks++; if ({rvalid0, rvalid1} !== 2'b00 || rdata !== {160'h0, 32'hFFF5_000A}) begin n_fail++; $display("FAIL idle_hold: got v%b%b %h expected v00 held data", rvalid0, rvalid1, rdata); end
  endtask

  task automatic test_vector();
    req1 = 1; addr1 = 32'd100; vec1 = 1;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b01 || rom_address !== 32'd100 || rom_isVector !== 1'b1) begin n_fail++; $display("FAIL vector_drive: got g%b%b a%0d v%b expected g01 a100 v1", gnt0, gnt1, rom_address, rom_isVector); end
    step();
    idle_inputs();
    n_checks++; if ({rvalid0, rvalid1} !== 2'b01) begin n_fail++; $display("FAIL vector_rvalid: got %b%b expected 01", rvalid0, rvalid1); end
    n_checks++; if (rdata !== {32'hFF96_0069, 32'hFF97_0068, 32'hFF98_0067, 32'hFF99_0066, 32'hFF9A_0065, 32'hFF9B_0064}) begin n_fail++; $display("FAIL vector_rdata: got %h", rdata); end
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL vector_rerr: got %b expected 0", rerr); end
    step();
  endtask

  task automatic test_contention();
    logic exp_g0;
    req0 = 1; addr0 = 32'd200; vec0 = 0;
    req1 = 1; addr1 = 32'd300; vec1 = 1;
    for (int i = 0; i < 6; i++) begin
      exp_g0 = (i % 2 == 0);
      #1;
      n_checks++; if ({gnt0, gnt1} !== {exp_g0, !exp_g0}) begin n_fail++; $display("FAIL contention_gnt%0d: got %b%b expected %b%b", i, gnt0, gnt1, exp_g0, !exp_g0); end
      step();
      n_checks++; if ({rvalid0, rvalid1} !== {exp_g0, !exp_g0}) begin n_fail++; $display("FAIL contention_rvalid%0d: got %b%b expected %b%b", i, rvalid0, rvalid1, exp_g0, !exp_g0); end
      n_checks++; if (rdata !== (exp_g0 ? words(32'd200, 1) : words(32'd300, NW))) begin n_fail++; $display("FAIL contention_rdata%0d: got %h", i, rdata); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_bounds();
    req0 = 1; addr0 = 32'd29995; vec0 = 1;
    step();
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    n_checks++; if (rvalid0 !== 1'b1 || rerr !== 1'b1 || rdata !== '0) begin n_fail++; $display("FAIL bounds_29995: got v%b e%b %h expected v1 e1 0", rvalid0, rerr, rdata); end
`else
    n_checks++; if (rvalid0 !== 1'b1 || rerr !== 1'b0 || rdata !== words(32'd29995, NW)) begin n_fail++; $display("FAIL nobounds_29995: got v%b e%b %h expected v1 e0 %h", rvalid0, rerr, rdata, words(32'd29995, NW)); end
`endif
    addr0 = 32'd29994;
    step();
    n_checks++; if (rerr !== 1'b0 || rdata !== words(32'd29994, NW)) begin n_fail++; $display("FAIL bounds_29994: got e%b %h expected e0 %h", rerr, rdata, words(32'd29994, NW)); end
    addr0 = 32'hFFFF_FFFE; vec0 = 0;
    #1;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    n_checks++; if (rom_address !== '0) begin n_fail++; $display("FAIL bounds_rom_addr: got %h expected 0", rom_address); end
    step();
    n_checks++; if (rerr !== 1'b1 || rdata !== '0) begin n_fail++; $display("FAIL bounds_wrap: got e%b %h expected e1 0", rerr, rdata); end
`else
    n_checks++; if (rom_address !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL nobounds_rom_addr: got %h expected fffffffe", rom_address); end
    step();
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL nobounds_wrap: got e%b expected e0", rerr); end
`endif
    idle_inputs();
    step();
    n_checks++; if (rerr !== 1'b0 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL bounds_clear: got e%b v%b expected e0 v0", rerr, rvalid0); end
  endtask

  task automatic test_back_to_back();
    req0 = 1; vec0 = 0;
    for (int i = 1; i <= 3; i++) begin
      addr0 = 32'(i);
      step();
      n_checks++; if (rvalid0 !== 1'b1 || rdata !== words(32'(i), 1)) begin n_fail++; $display("FAIL b2b_%0d: got v%b %h expected v1 %h", i, rvalid0, rdata, words(32'(i), 1)); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1; addr0 = 32'd40;
    step();
    idle_inputs();
    rst = 1; req1 = 1; addr1 = 32'd50;
    #1;
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt1: got %b expected 0", gnt1); end
    step();
    n_checks++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL midrst_resp: got v%b%b %h expected v00 0", rvalid0, rvalid1, rdata); end
    rst = 0; req0 = 1; addr0 = 32'd60;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL midrst_tie: got %b%b expected 10", gnt0, gnt1); end
    step();
    n_checks++; if ({rvalid0, rvalid1} !== 2'b10 || rdata !== words(32'd60, 1)) begin n_fail++; $display("FAIL midrst_after: got v%b%b %h", rvalid0, rvalid1, rdata); end
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL midrst_next: got %b%b expected 01", gnt0, gnt1); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector();
    test_contention();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
